// File: rtl/egress_arb_pkg.sv
// Shared types and constants for the egress frame arbiter: FSM encoding,
// frame word geometry and the byte-length to word-count conversion.
package egress_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } arb_state_t;

  localparam int FRAME_WORD_BYTES = 16;
  localparam int MAX_FRAME_WORDS  = 128;
  localparam int FRAME_LEN_BITS   = 11;
  localparam int FRAME_DATA_BITS  = FRAME_WORD_BYTES * 8;
  localparam int WORD_CNT_BITS    = $clog2(MAX_FRAME_WORDS) + 1;

  // Round a byte length up to whole 16-byte words. The 12-bit sum keeps the
  // carry from 2047+15, so the largest frame yields exactly 128 words.
  // A zero length, which a well-behaved source never presents, is treated
  // as a single word so the stream always terminates.
  function automatic logic [WORD_CNT_BITS-1:0] frame_words(
    input logic [FRAME_LEN_BITS-1:0] len
  );
    logic [FRAME_LEN_BITS:0] padded;
    padded = {1'b0, len} + (FRAME_LEN_BITS+1)'(FRAME_WORD_BYTES - 1);
    frame_words = padded[FRAME_LEN_BITS:$clog2(FRAME_WORD_BYTES)];
    if (frame_words == '0) begin
      frame_words = WORD_CNT_BITS'(1);
    end
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr (wrapping) wins, reported as one-hot, as an index and as an any flag.
module round_robin_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  // Walk from the farthest candidate back to ptr so the closest one is the
  // last assignment standing.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/egress_frame_arbiter.sv
// Round-robin frame scheduler feeding the shared egress write bus: grants one
// whole frame at a time once every destination port has room for it.
module egress_frame_arbiter
  import egress_arb_pkg::*;
#(
  parameter int NUM_SOURCES    = 4,
  parameter int NUM_PORTS      = 15,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                                 clk_ram_ctl,
  input  logic                                 rst_n,
  input  logic [NUM_SOURCES-1:0]               src_req,
  input  logic [NUM_SOURCES*NUM_PORTS-1:0]     src_dest,
  input  logic [NUM_SOURCES*FRAME_LEN_BITS-1:0] src_len,
  output logic [NUM_SOURCES-1:0]               src_rd_en,
  input  logic [NUM_SOURCES*FRAME_DATA_BITS-1:0] src_rd_data,
  output logic [NUM_SOURCES-1:0]               src_done,
  input  logic [NUM_PORTS-1:0]                 port_space_avail,
  output logic                                 frame_valid,
  output logic                                 frame_last,
  output logic [FRAME_DATA_BITS-1:0]           frame_data,
  output logic [FRAME_LEN_BITS-1:0]            frame_len,
  output logic [NUM_PORTS-1:0]                 frame_port_wr,
  output logic                                 busy,
  output logic [31:0]                          frames_fwd,
  output logic [31:0]                          frames_dropped,
  output arb_state_t                           dbg_state
);

  // Source handshake: src_rd_en[i] high in cycle t pops one word, which the
  // source presents on its src_rd_data slice during t+1 only. src_done[i]
  // rises together with the final src_rd_en of a frame and pops its header.
  // There is no back-pressure from the egress side: once granted, a frame
  // streams one word per cycle because port space was checked up front.

  localparam int SW       = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int HOLD_LEN = (HOLDOFF_CYCLES == 0) ? 1 : HOLDOFF_CYCLES;
  localparam int HW       = $clog2(HOLD_LEN + 1);

  arb_state_t                 state;
  logic [SW-1:0]              rr_ptr;
  logic [SW-1:0]              grant_idx;
  logic [NUM_PORTS-1:0]       dest_q;
  logic [FRAME_LEN_BITS-1:0]  len_q;
  logic [WORD_CNT_BITS-1:0]   last_idx;
  logic [WORD_CNT_BITS-1:0]   word_cnt;
  logic [HW-1:0]              hold_cnt;

  logic [NUM_PORTS-1:0]       head_dest [NUM_SOURCES];
  logic [FRAME_LEN_BITS-1:0]  head_len  [NUM_SOURCES];
  logic [FRAME_DATA_BITS-1:0] rd_word   [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]     eligible;

  logic [NUM_SOURCES-1:0]     pick_onehot;
  logic [SW-1:0]              pick_idx;
  logic                       pick_any;
  logic [WORD_CNT_BITS-1:0]   pick_words;

  // A zero destination mask has no ports to wait on, so it is always eligible.
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      head_dest[i] = src_dest[i*NUM_PORTS +: NUM_PORTS];
      head_len[i]  = src_len[i*FRAME_LEN_BITS +: FRAME_LEN_BITS];
      rd_word[i]   = src_rd_data[i*FRAME_DATA_BITS +: FRAME_DATA_BITS];
      eligible[i]  = src_req[i] && ((head_dest[i] & ~port_space_avail) == '0);
    end
  end

  round_robin_picker #(
    .N  (NUM_SOURCES),
    .PW (SW)
  ) u_picker (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign pick_words = frame_words(head_len[pick_idx]);

  // Scheduler FSM. src_rd_en/src_done are registered here, so they are set
  // one edge ahead of the cycle in which the word is popped.
  always_ff @(posedge clk_ram_ctl) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      dest_q    <= '0;
      len_q     <= '0;
      last_idx  <= '0;
      word_cnt  <= '0;
      hold_cnt  <= '0;
      src_rd_en <= '0;
      src_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= STREAM;
            grant_idx <= pick_idx;
            dest_q    <= head_dest[pick_idx];
            len_q     <= head_len[pick_idx];
            last_idx  <= pick_words - WORD_CNT_BITS'(1);
            word_cnt  <= '0;
            src_rd_en <= pick_onehot;
            src_done  <= (pick_words == WORD_CNT_BITS'(1)) ? pick_onehot : '0;
            if (pick_idx == SW'(NUM_SOURCES - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= pick_idx + SW'(1);
            end
          end
        end
        STREAM: begin
          if (word_cnt == last_idx) begin
            src_rd_en <= '0;
            src_done  <= '0;
            hold_cnt  <= '0;
            state     <= HOLD;
          end else begin
            word_cnt <= word_cnt + WORD_CNT_BITS'(1);
            if (word_cnt + WORD_CNT_BITS'(1) == last_idx) begin
              src_done <= src_rd_en;
            end
          end
        end
        HOLD: begin
          // Lets port_space_avail catch up with the frame just written.
          if (hold_cnt == HW'(HOLD_LEN - 1)) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: qualifiers registered from the pop cycle line up with the
  // source's one-cycle-late data, which is muxed in combinationally.
  always_ff @(posedge clk_ram_ctl) begin
    if (!rst_n) begin
      frame_valid    <= 1'b0;
      frame_last     <= 1'b0;
      frame_len      <= '0;
      frame_port_wr  <= '0;
      frames_fwd     <= '0;
      frames_dropped <= '0;
    end else begin
      frame_valid   <= |src_rd_en;
      frame_last    <= |src_done;
      frame_len     <= (|src_done) ? len_q : '0;
      frame_port_wr <= (|src_rd_en) ? dest_q : '0;
      if (|src_done) begin
        if (dest_q == '0) begin
          frames_dropped <= frames_dropped + 32'd1;
        end else begin
          frames_fwd <= frames_fwd + 32'd1;
        end
      end
    end
  end

  assign frame_data = frame_valid ? rd_word[grant_idx] : '0;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_egress_frame_arbiter.sv
// Self-checking bench for egress_frame_arbiter: directed scenarios followed by
// random traffic, compared cycle by cycle against a frame-level schedule model.
module tb_egress_frame_arbiter;
  import egress_arb_pkg::*;

  localparam int NS   = 4;
  localparam int NP   = 15;
  localparam int HOLD = 2;

  // ---------------- clock / reset ----------------
  logic clk_ram_ctl = 1'b0;
  always #5 clk_ram_ctl = ~clk_ram_ctl;

  logic                 rst_n;
  logic [NS-1:0]        src_req;
  logic [NS*NP-1:0]     src_dest;
  logic [NS*11-1:0]     src_len;
  logic [NS-1:0]        src_rd_en;
  logic [NS*128-1:0]    src_rd_data;
  logic [NS-1:0]        src_done;
  logic [NP-1:0]        port_space_avail;
  logic                 frame_valid;
  logic                 frame_last;
  logic [127:0]         frame_data;
  logic [10:0]          frame_len;
  logic [NP-1:0]        frame_port_wr;
  logic                 busy;
  logic [31:0]          frames_fwd;
  logic [31:0]          frames_dropped;
  arb_state_t           dbg_state;

  egress_frame_arbiter #(
    .NUM_SOURCES    (NS),
    .NUM_PORTS      (NP),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk_ram_ctl      (clk_ram_ctl),
    .rst_n            (rst_n),
    .src_req          (src_req),
    .src_dest         (src_dest),
    .src_len          (src_len),
    .src_rd_en        (src_rd_en),
    .src_rd_data      (src_rd_data),
    .src_done         (src_done),
    .port_space_avail (port_space_avail),
    .frame_valid      (frame_valid),
    .frame_last       (frame_last),
    .frame_data       (frame_data),
    .frame_len        (frame_len),
    .frame_port_wr    (frame_port_wr),
    .busy             (busy),
    .frames_fwd       (frames_fwd),
    .frames_dropped   (frames_dropped),
    .dbg_state        (dbg_state)
  );

  // ---------------- model state ----------------
  typedef struct {
    int          fid;
    logic [NP-1:0] dest;
    logic [10:0] len;
  } frm_t;

  typedef struct {
    logic [NS-1:0] rd_en;
    logic [NS-1:0] done;
    logic          valid;
    logic          last;
    logic [10:0]   len;
    logic [NP-1:0] port;
    logic [127:0]  data;
    logic          busy;
    bit            inc_fwd;
    bit            inc_drop;
  } exp_t;

  frm_t  sq[NS][$];     // what each source holds (driven to the DUT)
  frm_t  mq[NS][$];     // frames the model has not yet granted
  int    pos[NS];
  exp_t  sched[int];    // expected outputs keyed by cycle number
  int    cyc, next_free, rr, n_grants, fid_next;
  logic [31:0] m_fwd, m_drop;
  int    vectors, miscompares;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [127:0] word_of(input int s, input int fid, input int k);
    logic [31:0] h;
    h = (fid * 32'h9E3779B1) ^ (k * 32'h85EBCA6B);
    return {8'(s), 16'(fid), 8'(k), h, ~h, h ^ 32'h5A5A5A5A};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic exp_t get_exp(input int c);
    exp_t e;
    e = '{default: '0};
    if (sched.exists(c)) e = sched[c];
    return e;
  endfunction

  function automatic int words_of(input logic [10:0] len);
    int w;
    w = (int'(len) + 15) / 16;
    return (w == 0) ? 1 : w;
  endfunction

  // A frame granted at cycle a pops words in a+1..a+W, shows them at
  // a+2..a+W+1, keeps the arbiter busy through the hold-off gap.
  task automatic schedule(input int s, input frm_t f, input int a);
    exp_t e;
    int   w;
    w = words_of(f.len);
    for (int k = 0; k < w; k++) begin
      e = get_exp(a + 1 + k);
      e.rd_en[s] = 1'b1;
      if (k == w - 1) e.done[s] = 1'b1;
      sched[a + 1 + k] = e;
      e = get_exp(a + 2 + k);
      e.valid = 1'b1;
      e.port  = f.dest;
      e.data  = word_of(s, f.fid, k);
      if (k == w - 1) begin
        e.last = 1'b1;
        e.len  = f.len;
        if (f.dest == '0) e.inc_drop = 1'b1;
        else              e.inc_fwd  = 1'b1;
      end
      sched[a + 2 + k] = e;
    end
    for (int c = a + 1; c <= a + w + HOLD; c++) begin
      e = get_exp(c);
      e.busy = 1'b1;
      sched[c] = e;
    end
  endtask

  task automatic model_decide();
    if (rst_n !== 1'b1 || cyc < next_free) return;
    for (int k = 0; k < NS; k++) begin
      int s;
      s = (rr + k) % NS;
      if (mq[s].size() > 0 && ((mq[s][0].dest & ~port_space_avail) == '0)) begin
        frm_t f;
        f = mq[s].pop_front();
        schedule(s, f, cyc);
        rr        = (s + 1) % NS;
        next_free = cyc + words_of(f.len) + HOLD + 1;
        n_grants++;
        return;
      end
    end
  endtask

  task automatic compare();
    exp_t e;
    e = get_exp(cyc);
    if (e.inc_fwd)  m_fwd++;
    if (e.inc_drop) m_drop++;
    chk("src_rd_en",      src_rd_en,      e.rd_en);
    chk("src_done",       src_done,       e.done);
    chk("frame_valid",    frame_valid,    e.valid);
    chk("frame_last",     frame_last,     e.last);
    chk("frame_len",      frame_len,      e.len);
    chk("frame_port_wr",  frame_port_wr,  e.port);
    chk("frame_data",     frame_data,     e.data);
    chk("busy",           busy,           e.busy);
    chk("dbg_state_idle", dbg_state == IDLE, !e.busy);
    chk("frames_fwd",     frames_fwd,     m_fwd);
    chk("frames_dropped", frames_dropped, m_drop);
    if (sched.exists(cyc)) sched.delete(cyc);
  endtask

  // ---------------- driver tasks (source behaviour) ----------------
  task automatic drive_sources();
    for (int i = 0; i < NS; i++) begin
      src_req[i] = (sq[i].size() > 0);
      if (sq[i].size() > 0) begin
        src_dest[i*NP +: NP] = sq[i][0].dest;
        src_len[i*11 +: 11]  = sq[i][0].len;
      end else begin
        src_dest[i*NP +: NP] = NP'($urandom());
        src_len[i*11 +: 11]  = 11'($urandom());
      end
    end
  endtask

  task automatic add_frame(input int s, input logic [NP-1:0] dest, input logic [10:0] len);
    frm_t f;
    f.fid  = fid_next;
    f.dest = dest;
    f.len  = len;
    fid_next++;
    sq[s].push_back(f);
    mq[s].push_back(f);
    drive_sources();
  endtask

  task automatic source_update(input logic [NS-1:0] rd_s, input logic [NS-1:0] done_s);
    for (int i = 0; i < NS; i++) begin
      if (rd_s[i] && sq[i].size() > 0) begin
        src_rd_data[i*128 +: 128] = word_of(i, sq[i][0].fid, pos[i]);
        pos[i]++;
      end else begin
        src_rd_data[i*128 +: 128] = rand128();
      end
      if (done_s[i] && sq[i].size() > 0) begin
        void'(sq[i].pop_front());
        pos[i] = 0;
      end
    end
  endtask

  task automatic tick();
    logic [NS-1:0] rd_s, done_s;
    logic          rst_s;
    model_decide();
    @(negedge clk_ram_ctl);
    compare();
    rd_s   = src_rd_en;
    done_s = src_done;
    rst_s  = rst_n;
    @(posedge clk_ram_ctl);
    #1;
    cyc++;
    if (rst_s !== 1'b1) begin
      sched.delete();
      m_fwd     = '0;
      m_drop    = '0;
      rr        = 0;
      next_free = 0;
      for (int i = 0; i < NS; i++) begin
        sq[i].delete();
        mq[i].delete();
        pos[i] = 0;
        src_rd_data[i*128 +: 128] = rand128();
      end
    end else begin
      source_update(rd_s, done_s);
    end
    drive_sources();
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NS; i++) if (mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int max_cycles);
    int budget;
    budget = max_cycles;
    while (budget > 0 && (any_pending() || cyc <= next_free + 2)) begin
      tick();
      budget--;
    end
    chk("drain_budget", budget > 0, 1'b1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int g0, guard, pend;
    logic [10:0]   rlen;
    logic [NP-1:0] rdest;
    vectors = 0; miscompares = 0;
    cyc = 0; next_free = 0; rr = 0; n_grants = 0; fid_next = 1;
    m_fwd = '0; m_drop = '0;
    rst_n = 1'b0;
    port_space_avail = '1;
    src_req = '0; src_dest = '0; src_len = '0; src_rd_data = '0;
    for (int i = 0; i < NS; i++) pos[i] = 0;
    @(posedge clk_ram_ctl);
    #1;
    repeat (3) tick();
    rst_n = 1'b1;

    // single 64-byte frame to port 0
    add_frame(0, 15'h0001, 11'd64);
    run_until_idle(300);
    chk("t1_frames_fwd", frames_fwd, 32'd1);

    // word-count boundaries 17 / 16 / 2047 bytes
    add_frame(1, 15'h0008, 11'd17);
    add_frame(1, 15'h0008, 11'd16);
    add_frame(1, 15'h7fff, 11'd2047);
    run_until_idle(800);
    chk("t2_frames_fwd", frames_fwd, 32'd4);

    // park the pointer on source 0, then three sources contend
    add_frame(3, 15'h0100, 11'd16);
    run_until_idle(100);
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++) add_frame(s, 15'h0010, 11'd16);
    run_until_idle(300);
    chk("t3_frames_fwd", frames_fwd, 32'd11);

    // blocked destination is skipped until space returns
    port_space_avail[1] = 1'b0;
    add_frame(0, 15'h0002, 11'd32);
    add_frame(1, 15'h0004, 11'd32);
    repeat (30) tick();
    chk("t4_src0_waiting", sq[0].size(), 1);
    port_space_avail[1] = 1'b1;
    run_until_idle(200);
    chk("t4_frames_fwd", frames_fwd, 32'd13);

    // zero destination mask is drained and dropped
    add_frame(2, 15'h0000, 11'd48);
    run_until_idle(200);
    chk("t5_frames_dropped", frames_dropped, 32'd1);
    chk("t5_frames_fwd", frames_fwd, 32'd13);

    // reset after two of four words
    add_frame(0, 15'h0001, 11'd64);
    g0 = n_grants;
    guard = 0;
    while (n_grants == g0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("t6_grant_seen", n_grants, g0 + 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("t6_busy_after_reset", busy, 1'b0);
    add_frame(1, 15'h0020, 11'd16);
    add_frame(0, 15'h0040, 11'd16);
    run_until_idle(200);
    chk("t6_frames_fwd", frames_fwd, 32'd2);

    // random traffic with fluctuating port space
    for (int n = 0; n < 600; n++) begin
      pend = 0;
      for (int i = 0; i < NS; i++) pend += mq[i].size();
      if ($urandom_range(0, 7) == 0 && pend < 12) begin
        case ($urandom_range(0, 5))
          0:       rlen = 11'd1;
          1:       rlen = 11'd16;
          2:       rlen = 11'd17;
          3:       rlen = 11'd2047;
          default: rlen = 11'($urandom_range(1, 300));
        endcase
        rdest = ($urandom_range(0, 5) == 0) ? '0 : NP'($urandom_range(1, 32767));
        add_frame($urandom_range(0, NS - 1), rdest, rlen);
      end
      if ($urandom_range(0, 15) == 0) begin
        port_space_avail = '1;
        port_space_avail[$urandom_range(0, NP - 1)] = 1'b0;
        if ($urandom_range(0, 1) == 0) port_space_avail = '1;
      end
      tick();
    end
    port_space_avail = '1;
    run_until_idle(4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
